// File: rtl/quad_pkg.sv
// Shared types and Gray-code adjacency helpers for the quadrature step decoder.
package quad_pkg;

    typedef enum logic {INIT, TRACK} qd_state_t;

    typedef logic [1:0] ab_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00 on {A,B}.
    function automatic logic qd_fwd(ab_t prev, ab_t cur);
        logic r;
        case (prev)
            2'b00:   r = (cur == 2'b01);
            2'b01:   r = (cur == 2'b11);
            2'b11:   r = (cur == 2'b10);
            2'b10:   r = (cur == 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic qd_rev(ab_t prev, ab_t cur);
        logic r;
        case (prev)
            2'b00:   r = (cur == 2'b10);
            2'b10:   r = (cur == 2'b11);
            2'b11:   r = (cur == 2'b01);
            2'b01:   r = (cur == 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one asynchronous input.
module quad_filter #(
    parameter int FILT = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    input  logic force_load,
    output logic sync,
    output logic q,
    output logic stable
);

    localparam int            CW   = $clog2(FILT + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT - 1);
    localparam logic [CW-1:0] FULL = CW'(FILT);

    logic          meta;
    logic [CW-1:0] run_cnt;
    logic [CW-1:0] agree_cnt;

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (srst) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            q         <= 1'b0;
            run_cnt   <= '0;
            agree_cnt <= '0;
        end else begin
            meta <= d;
            sync <= meta;
            if (force_load) begin
                q         <= sync;
                run_cnt   <= '0;
                agree_cnt <= '0;
            end else if (sync != q) begin
                agree_cnt <= '0;
                // The FILT-th differing cycle is the one that commits the new value.
                if (run_cnt == LAST) begin
                    q       <= sync;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
                if (agree_cnt != FULL)
                    agree_cnt <= agree_cnt + 1'b1;
            end
        end
    end

    assign stable = (agree_cnt == FULL);

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B + index front end producing up/down/load strobes for an up/down/load counter.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int             W    = 8,
    parameter int             FILT = 4,
    parameter logic [W-1:0]   HOME = '0
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         idx_in,
    input  logic         idx_en,
    input  logic         err_clr,
    output logic         up,
    output logic         down,
    output logic         load,
    output logic [W-1:0] data,
    output logic         dir,
    output logic         err
);

    qd_state_t state;
    ab_t       prev;
    ab_t       cur_ab;
    logic      idx_prev;

    logic a_sync, b_sync, i_sync;
    logic a_filt, b_filt, i_filt;
    logic a_stable, b_stable, i_stable;
    logic force_load;

    logic step_fwd, step_rev, step_bad, idx_rise;

    quad_filter #(.FILT(FILT)) u_filt_a (
        .clk(clk), .srst(srst), .d(a_in), .force_load(force_load),
        .sync(a_sync), .q(a_filt), .stable(a_stable)
    );

    quad_filter #(.FILT(FILT)) u_filt_b (
        .clk(clk), .srst(srst), .d(b_in), .force_load(force_load),
        .sync(b_sync), .q(b_filt), .stable(b_stable)
    );

    quad_filter #(.FILT(FILT)) u_filt_idx (
        .clk(clk), .srst(srst), .d(idx_in), .force_load(force_load),
        .sync(i_sync), .q(i_filt), .stable(i_stable)
    );

    assign cur_ab     = {a_filt, b_filt};
    // Leaving INIT snaps the filters to the synchronized inputs so a non-zero rest state is not a step.
    assign force_load = (state == INIT) && a_stable && b_stable && i_stable;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        step_fwd = 1'b0;
        step_rev = 1'b0;
        step_bad = 1'b0;
        idx_rise = 1'b0;
        if (state == TRACK) begin
            step_fwd = qd_fwd(prev, cur_ab);
            step_rev = qd_rev(prev, cur_ab);
            step_bad = ((prev ^ cur_ab) == 2'b11);
            idx_rise = i_filt & ~idx_prev & idx_en;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state    <= INIT;
            prev     <= '0;
            idx_prev <= 1'b0;
            up       <= 1'b0;
            down     <= 1'b0;
            load     <= 1'b0;
            data     <= '0;
            dir      <= 1'b0;
            err      <= 1'b0;
        end else begin
            // A home load outranks a coincident step; direction still follows the step.
            up   <= step_fwd & ~idx_rise;
            down <= step_rev & ~idx_rise;
            load <= idx_rise;
            data <= idx_rise ? HOME : '0;

            if (step_fwd)
                dir <= 1'b1;
            else if (step_rev)
                dir <= 1'b0;

            if (step_bad)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;

            case (state)
                INIT: begin
                    if (force_load) begin
                        state    <= TRACK;
                        prev     <= {a_sync, b_sync};
                        idx_prev <= i_sync;
                    end
                end
                TRACK: begin
                    prev     <= cur_ab;
                    idx_prev <= i_filt;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Randomized and directed bench for quad_step_decoder against a cycle-level behavioural model.
module tb_quad_step_decoder;
    import quad_pkg::*;

    localparam int          W    = 8;
    localparam int          FILT = 4;
    localparam logic [7:0]  HOME = 8'h40;
    localparam int          LAT  = FILT + 3;

    logic clk = 1'b0;
    logic srst = 1'b1;
    logic a_in = 1'b0, b_in = 1'b0, idx_in = 1'b0, idx_en = 1'b0, err_clr = 1'b0;
    logic up, down, load, dir, err;
    logic [W-1:0] data;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    quad_step_decoder #(.W(W), .FILT(FILT), .HOME(HOME)) dut (
        .clk(clk), .srst(srst), .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
        .idx_en(idx_en), .err_clr(err_clr), .up(up), .down(down), .load(load),
        .data(data), .dir(dir), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position along the forward cycle: Gray {A,B} converted to binary.
    function automatic int pos(input logic [1:0] ab);
        return int'({ab[1], ab[1] ^ ab[0]});
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        logic [1:0] q;
        q = 2'(p);
        return {q[1], q[1] ^ q[0]};
    endfunction

    // Behavioural model: per channel a sample pipeline, a differing-run and an agreeing-run count.
    bit         s1_m[3], s2_m[3], fv_m[3];
    int         run_m[3], agree_m[3];
    bit         trk_m = 1'b0;
    logic [1:0] prev_m = 2'b00;
    bit         iprev_m = 1'b0;
    bit         e_up = 1'b0, e_down = 1'b0, e_load = 1'b0, e_dir = 1'b0, e_err = 1'b0;
    logic [7:0] e_data = 8'h00;

    always @(posedge clk) begin
        bit raw[3];
        bit was_trk, all_ok, frc;
        int d;
        raw[0] = a_in; raw[1] = b_in; raw[2] = idx_in;
        if (srst) begin
            for (int c = 0; c < 3; c++) begin
                s1_m[c] = 0; s2_m[c] = 0; fv_m[c] = 0; run_m[c] = 0; agree_m[c] = 0;
            end
            trk_m = 0; prev_m = 2'b00; iprev_m = 0;
            e_up = 0; e_down = 0; e_load = 0; e_data = 8'h00; e_dir = 0; e_err = 0;
        end else begin
            was_trk = trk_m;
            all_ok  = (agree_m[0] == FILT) && (agree_m[1] == FILT) && (agree_m[2] == FILT);
            frc     = !was_trk && all_ok;
            e_up = 0; e_down = 0; e_load = 0; e_data = 8'h00;
            if (err_clr) e_err = 0;
            if (was_trk) begin
                d = (pos({fv_m[0], fv_m[1]}) - pos(prev_m) + 4) % 4;
                if (fv_m[2] && !iprev_m && idx_en) begin
                    e_load = 1; e_data = HOME;
                end else begin
                    e_up = (d == 1); e_down = (d == 3);
                end
                if (d == 1) e_dir = 1;
                else if (d == 3) e_dir = 0;
                if (d == 2) e_err = 1;
                prev_m  = {fv_m[0], fv_m[1]};
                iprev_m = fv_m[2];
            end
            if (frc) begin
                trk_m   = 1;
                prev_m  = {s2_m[0], s2_m[1]};
                iprev_m = s2_m[2];
            end
            for (int c = 0; c < 3; c++) begin
                if (frc) begin
                    fv_m[c] = s2_m[c]; run_m[c] = 0; agree_m[c] = 0;
                end else if (s2_m[c] != fv_m[c]) begin
                    agree_m[c] = 0;
                    run_m[c]++;
                    if (run_m[c] == FILT) begin
                        fv_m[c] = s2_m[c]; run_m[c] = 0;
                    end
                end else begin
                    run_m[c] = 0;
                    if (agree_m[c] < FILT) agree_m[c]++;
                end
                s2_m[c] = s1_m[c];
                s1_m[c] = raw[c];
            end
        end
    end

    // Per-cycle comparison plus strobe bookkeeping for the directed expectations.
    int n_up = 0, n_down = 0, n_load = 0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (chk_on) begin
            check("outputs", 32'({up, down, load, dir, err, data}),
                  32'({e_up, e_down, e_load, e_dir, e_err, e_data}));
            if (up) n_up++;
            if (down) n_down++;
            if (load) begin
                n_load++;
                last_data = data;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic [1:0] ab);
        a_in = ab[1];
        b_in = ab[0];
    endtask

    // which: 0 = up, 1 = down, 2 = load; bounded wait over 20 cycles.
    task automatic wait_strobe(input string name, input int which);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (lat == 0 && ((which == 0 && up) || (which == 1 && down) || (which == 2 && load)))
                lat = i;
        end
        check(name, lat, LAT);
    endtask

    initial begin
        int u0, d0, l0, k, n, p;
        logic [1:0] ab;
        logic [7:0] ctr;
        logic [1:0] fwd_seq [4];
        logic [1:0] rev_seq [4];
        fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        rev_seq = '{2'b10, 2'b11, 2'b01, 2'b00};

        // Reset with inputs resting at A=1, B=1, idx=0.
        srst = 1'b1; a_in = 1'b1; b_in = 1'b1; idx_in = 1'b0;
        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("reset_outputs", 32'({up, down, load, dir, err, data}), 32'h0);
        srst = 1'b0;
        idle(20);
        check("init_reaches_track", 32'(dut.state), 32'(TRACK));
        check("init_no_strobes", n_up + n_down + n_load, 0);
        check("init_no_err", 32'(err), 0);

        // Walk forward from 11 to 00, then a full forward sweep.
        set_ab(2'b10); wait_strobe("fwd_lat_11_10", 0);
        set_ab(2'b00); wait_strobe("fwd_lat_10_00", 0);
        u0 = n_up; d0 = n_down;
        for (int i = 0; i < 4; i++) begin
            set_ab(fwd_seq[i]);
            wait_strobe("fwd_sweep_lat", 0);
        end
        check("fwd_up_count", n_up - u0, 4);
        check("fwd_no_down", n_down - d0, 0);
        check("fwd_dir", 32'(dir), 1);

        // Reverse 8 steps with an attached counter starting at 5.
        u0 = n_up; d0 = n_down;
        for (int i = 0; i < 8; i++) begin
            set_ab(rev_seq[i % 4]);
            wait_strobe("rev_sweep_lat", 1);
        end
        ctr = 8'd5 + 8'(n_up - u0) - 8'(n_down - d0);
        check("rev_down_count", n_down - d0, 8);
        check("rev_dir", 32'(dir), 0);
        check("rev_counter_wrap", 32'(ctr), 32'd253);

        // Short glitch on A, then an illegal jump 00 -> 11, then clear.
        u0 = n_up; d0 = n_down;
        a_in = 1'b1; idle(3); a_in = 1'b0; idle(15);
        check("glitch_no_strobe", (n_up - u0) + (n_down - d0), 0);
        set_ab(2'b11); idle(15);
        check("jump_err_set", 32'(err), 1);
        check("jump_no_strobe", (n_up - u0) + (n_down - d0), 0);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        check("err_clr", 32'(err), 0);

        // Index with enable, index coincident with a forward step, index while disabled.
        idx_en = 1'b1; idx_in = 1'b1;
        wait_strobe("idx_lat", 2);
        check("idx_data", 32'(last_data), 32'h40);
        idx_in = 1'b0; idle(10);
        u0 = n_up; l0 = n_load;
        idx_in = 1'b1; set_ab(2'b10); idle(15);
        check("coincident_load", n_load - l0, 1);
        check("coincident_no_up", n_up - u0, 0);
        check("coincident_dir", 32'(dir), 1);
        idx_in = 1'b0; idle(10);
        idx_en = 1'b0; l0 = n_load;
        idx_in = 1'b1; idle(15);
        check("idx_disabled", n_load - l0, 0);
        idx_in = 1'b0; idle(10);

        // Reset partway through a step, re-settle, resume tracking.
        set_ab(2'b00); idle(3);
        srst = 1'b1; idle(1);
        check("midreset_outputs", 32'({up, down, load, dir, err, data}), 32'h0);
        srst = 1'b0;
        idle(20);
        set_ab(2'b01); wait_strobe("resume_lat", 0);
        check("resume_dir", 32'(dir), 1);

        // Randomized traffic; the per-cycle compare carries the checking.
        for (int i = 0; i < 400; i++) begin
            k  = $urandom_range(0, 9);
            ab = {a_in, b_in};
            if (k <= 4) begin
                p = (pos(ab) + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
                set_ab(ab_of(p));
            end else if (k == 5) begin
                set_ab(~ab);
            end else if (k == 6) begin
                n = $urandom_range(1, 6);
                if ($urandom_range(0, 1) == 1) begin
                    a_in = ~a_in; idle(n); a_in = ~a_in;
                end else begin
                    b_in = ~b_in; idle(n); b_in = ~b_in;
                end
            end else if (k == 7) begin
                idx_in = ~idx_in;
                idx_en = 1'($urandom_range(0, 1));
            end else if (k == 8) begin
                err_clr = 1'b1; idle(1); err_clr = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                srst = 1'b1; idle($urandom_range(1, 3)); srst = 1'b0;
            end
            idle($urandom_range(1, 10));
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
